// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles the fetch stage's bus signals.
//   imem_addr      fetch -> imem   byte address (equals pc)
//   imem_data      imem  -> fetch  instruction word for imem_addr, same cycle
//   stall          hazard unit     hold pc and IF/ID
//   redirect_valid branch unit     load redirect_pc, flush IF/ID
//   redirect_pc    branch unit     target address
//   if_valid/if_pc/if_pc_plus4/if_instr   IF/ID register outputs to decode
//   if_misalign    only when FETCH_MISALIGN_EN is defined
// Modports: master = fetch stage, slave = its environment (imem, hazard, decode).
interface inst_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_EN
    logic        if_misalign;
`endif

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_pc,
        output if_pc_plus4,
        output if_instr
`ifdef FETCH_MISALIGN_EN
        ,
        output if_misalign
`endif
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_pc,
        input  if_pc_plus4,
        input  if_instr
`ifdef FETCH_MISALIGN_EN
        ,
        input  if_misalign
`endif
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Holds the pc, presents it combinationally to a same-cycle instruction
// memory, and registers {pc, pc+4, instruction} into the IF/ID register.
// Priority at each rising edge: rst > redirect_valid > stall > normal fetch.
// Ports:
//   clk   core clock, all state on the rising edge
//   rst   synchronous reset, active-high
//   bus   inst_fetch_if.master (imem, hazard, redirect and IF/ID signals)
// Parameters:
//   RESET_PC   pc value loaded on reset
//   NOP_INSTR  bubble written into IF/ID on reset and flush
// Optional feature (macro FETCH_MISALIGN_EN): a redirect to a non-word-aligned
// target is aligned down, and the next IF/ID capture is a bubble-like slot
// with if_valid=1 and if_misalign=1 so decode can raise the exception.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_plus4_q;
    logic [31:0] if_instr_q;

    // Wraps modulo 2^32 on purpose.
    assign pc_next_seq = pc + 32'd4;

    assign bus.imem_addr   = pc;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus4 = if_pc_plus4_q;
    assign bus.if_instr    = if_instr_q;

`ifdef FETCH_MISALIGN_EN
    logic misalign_pend;
    logic if_misalign_q;

    assign bus.if_misalign = if_misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd4;
            if_instr_q    <= NOP_INSTR;
            misalign_pend <= 1'b0;
            if_misalign_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Target is aligned down; the pending flag remembers the fault
            // until the slot for the target is captured.
            pc            <= {bus.redirect_pc[31:2], 2'b00};
            misalign_pend <= (bus.redirect_pc[1:0] != 2'b00);
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            if_instr_q    <= NOP_INSTR;
            if_misalign_q <= 1'b0;
        end else if (!bus.stall) begin
            pc            <= pc_next_seq;
            if_valid_q    <= 1'b1;
            if_pc_q       <= pc;
            if_pc_plus4_q <= pc_next_seq;
            if (misalign_pend) begin
                // Fetched word is not executed; decode sees the fault slot.
                if_instr_q    <= NOP_INSTR;
                if_misalign_q <= 1'b1;
                misalign_pend <= 1'b0;
            end else begin
                if_instr_q    <= bus.imem_data;
                if_misalign_q <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd4;
            if_instr_q    <= NOP_INSTR;
        end else if (bus.redirect_valid) begin
            // Low address bits are kept; instruction memory ignores them.
            pc            <= bus.redirect_pc;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_pc_plus4_q <= 32'd0;
            if_instr_q    <= NOP_INSTR;
        end else if (!bus.stall) begin
            pc            <= pc_next_seq;
            if_valid_q    <= 1'b1;
            if_pc_q       <= pc;
            if_pc_plus4_q <= pc_next_seq;
            if_instr_q    <= bus.imem_data;
        end
    end
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage of the RV32I core. Holds the program counter and drives the instruction-memory byte address. The instruction memory is combinational, word-indexed by address[31:2], and returns the word in the same cycle. Each cycle the stage registers {pc, instruction} into the IF/ID pipeline register for decode. It also accepts stalls from the hazard unit and PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on reset and flush.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_addr  output  32  byte address to instruction memory; equals pc (combinational)
imem_data  input  32  instruction word returned for imem_addr in the same cycle
stall  input  1  hold pc and IF/ID contents
redirect_valid  input  1  load redirect_pc into pc and flush IF/ID
redirect_pc  input  32  branch/jump target
if_valid  output  1  IF/ID slot holds a real instruction
if_pc  output  32  pc of the instruction in IF/ID
if_pc_plus4  output  32  if_pc + 4, for JAL/JALR link
if_instr  output  32  instruction in IF/ID

Behaviour:
- Reset (rst=1 at an edge): pc <= RESET_PC, if_valid <= 0, if_pc <= 0, if_pc_plus4 <= 4, if_instr <= NOP_INSTR. Reset overrides stall and redirect. Reset mid-stream discards all in-flight state.
- imem_addr = pc, with no register in between. Latency is 1 cycle from pc to the IF/ID outputs.
- Priority at each edge when not in reset: redirect_valid > stall > normal.
- Normal (redirect_valid=0, stall=0):
  - if_pc <= pc; if_pc_plus4 <= pc+4; if_instr <= imem_data; if_valid <= 1.
  - pc <= pc+4.
- Stall (redirect_valid=0, stall=1): pc and all IF/ID registers hold their values. imem_addr is unchanged.
- Redirect (redirect_valid=1, regardless of stall):
  - pc <= redirect_pc.
  - IF/ID flushed: if_valid <= 0, if_instr <= NOP_INSTR, if_pc and if_pc_plus4 <= 0.
  - The instruction fetched in this cycle is discarded.
  - The first target instruction appears in IF/ID one cycle after the redirect edge.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- After reset, the first valid instruction (pc=RESET_PC) appears in IF/ID after the first non-stalled edge.
- Back-to-back redirects: each one flushes, and the last one wins.
- Without the optional feature, redirect_pc[1:0] is loaded as given. Memory ignores the low two bits.

Optional Feature:
Macro FETCH_MISALIGN_EN.
- Defined:
  - Adds output port if_misalign (1 bit, reset 0).
  - On a redirect with redirect_pc[1:0] != 0, pc <= {redirect_pc[31:2],2'b00}, and a pending-misalign flag is set.
  - The next IF/ID capture gets if_misalign=1, if_valid=1, if_instr=NOP_INSTR and if_pc = the aligned pc. Then the flag clears.
  - The flag holds across stalls. It is cleared by reset or by a later aligned redirect.
  - All other captures have if_misalign=0.
- Undefined: no port, no flag, behaviour as above.

Test Plan:
- Reset/sequential: bench memory model returns word 3 = 0x00100093 and word 4 = 0x00B00113. Use RESET_PC=0x0C, assert rst 2 cycles, then run.
  - Expect if_valid=0 and if_instr=0x00000013 during reset.
  - Next edge: if_pc=0x0C, if_instr=0x00100093, if_pc_plus4=0x10.
  - Following edge: if_pc=0x10, if_instr=0x00B00113.
- Stall: assert stall for 3 cycles while imem_addr=0x14. Expect imem_addr held at 0x14 and IF/ID unchanged all 3 cycles; fetch resumes at 0x14 after release.
- Redirect vs stall: stall=1 and redirect_valid=1 with redirect_pc=0x40 in the same cycle.
  - Next cycle: imem_addr=0x40, if_valid=0, if_instr=0x00000013.
  - Cycle after: if_pc=0x40, if_valid=1.
- Wrap: redirect to 0xFFFFFFFC, then run 2 cycles. Expect if_pc=0xFFFFFFFC with if_pc_plus4=0x00000000, then if_pc=0x00000000.
- Reset mid-operation: assert rst while stalled with a valid IF/ID. Next edge: pc=RESET_PC, if_valid=0.
- Misalign (FETCH_MISALIGN_EN defined): redirect_pc=0x22.
  - Expect imem_addr=0x20.
  - Next capture: if_misalign=1, if_instr=0x00000013, if_pc=0x20.
  - Following capture: if_misalign=0.
  - Build again with the macro undefined: port absent, pc=0x22.
